uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive stage that sits directly downstream of the baud tick generator. It consumes the oversampling tick, detects the start bit, and samples each bit at its mid-point. Frame format is runtime-selectable: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits. It delivers each received byte as a one-cycle valid pulse with parity and framing error flags.

Parameters:
SAMPLING_RATE, 16, ticks per bit period; must be even and at least 4.
SYNC_STAGES, 2, flip-flop stages in the i_rx synchroniser; must be at least 2.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset; asynchronous, active-low
i_tick  input  1  oversampling tick, one i_clk cycle wide, SAMPLING_RATE per bit
i_rx  input  1  serial line, idle high, asynchronous to i_clk
i_data_len  input  2  data bits: 00=5, 01=6, 10=7, 11=8
i_parity_en  input  1  1 = a parity bit follows the data bits
i_parity_odd  input  1  1 = odd parity, 0 = even parity
i_stop2  input  1  1 = two stop bits
o_data  output  8  received word, LSB-aligned, unused upper bits 0
o_valid  output  1  one-cycle pulse; o_data and error flags valid in this cycle
o_parity_err  output  1  parity mismatch in the last frame
o_frame_err  output  1  a stop bit was sampled low in the last frame
o_break  output  1  break detected (see Optional Feature)
o_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; tick counter and bit counter = 0.
  - Synchroniser flops = 1.
  - o_data = 0; o_valid, o_parity_err, o_frame_err, o_break, o_busy = 0.
  - Reset asserted mid-frame aborts the frame; no o_valid is produced.
- rx_s = i_rx after SYNC_STAGES flops. All sampling uses rx_s.
- All counters and state transitions advance only in cycles where i_tick=1. The only exception is o_valid, which drops to 0 on the next clock.
- Tick counter width: $clog2(SAMPLING_RATE).
- IDLE:
  - On a tick with rx_s=0: go to START, clear the tick counter.
  - On entry to START, latch i_data_len, i_parity_en, i_parity_odd and i_stop2. Config changes mid-frame are ignored.
- START:
  - Tick counter increments on each tick.
  - On the tick where counter == SAMPLING_RATE/2-1:
    - rx_s=0: go to DATA, clear tick and bit counters.
    - rx_s=1: glitch; return to IDLE with no output.
- DATA:
  - On the tick where counter == SAMPLING_RATE-1: store rx_s at shift index bit_cnt (LSB first), clear the counter, bit_cnt++.
  - After the (latched data_len + 5)th bit: go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Sample at counter == SAMPLING_RATE-1.
  - Expected bit = XOR of the received data bits, inverted when odd parity.
  - Mismatch sets the internal parity-error flag.
- STOP:
  - Sample at counter == SAMPLING_RATE-1; a 0 sets the internal frame-error flag.
  - If two stop bits are latched, sample a second stop bit one bit period later.
  - After the last stop sample, in the same clock:
    - o_data = shift register with bits above the data length forced to 0;
    - o_parity_err and o_frame_err = internal flags;
    - o_valid = 1 for one cycle.
  - Then go to IDLE. With no break, the next start bit can be accepted from the next tick.
- Error flags hold their value until the next o_valid, then update (including clearing).
- Latency: o_valid rises in the clock of the final stop-bit mid-point tick, i.e. (1+N+P+S-0.5) bit periods after the start edge (N = data bits, P = parity bits, S = stop bits).
- A line stuck low with no break support: each frame completes with o_frame_err=1. A new START is entered only on a tick with rx_s=0 while in IDLE.

Optional Feature:
Macro: UART_RX_BREAK_DET_EN
- Defined:
  - If every sampled bit of the frame (data, parity and stop) is 0, o_break=1 together with o_valid. o_frame_err is also 1.
  - The FSM then enters WAIT_IDLE and stays there until a tick with rx_s=1, then goes to IDLE. o_busy is high in WAIT_IDLE.
  - o_break holds its value until the next o_valid.
- Undefined:
  - o_break is tied to 0 and no WAIT_IDLE state exists.
  - An all-zero frame is reported only as o_frame_err=1.

Test Plan:
- 8N1 reception: tick every 4 clocks; send 0xA5 → one o_valid pulse, o_data=0xA5, o_parity_err=0, o_frame_err=0, o_busy low after the pulse.
- 7E1 parity: send 7 bits 0x35 with a correct parity bit → o_data=0x35, parity_err=0. Repeat with the parity bit flipped → parity_err=1, o_data=0x35.
- 5O2 framing error: send 0x1F with odd parity and two stop bits, second stop bit driven 0 → o_data=0x1F, o_frame_err=1.
- Start glitch: drive i_rx low for 3 ticks then high → no o_valid, FSM returns to IDLE. A following 0x3C is received correctly.
- Reset mid-frame: assert i_rst_n during data bit 3 of 0xFF → all outputs 0 immediately, no o_valid. After release, 0x81 is received.
- Break (UART_RX_BREAK_DET_EN defined): hold i_rx low for 20 bit periods → o_valid with o_break=1, o_frame_err=1, o_data=0x00. o_busy stays high until i_rx returns high. The next frame 0x55 is received.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampled UART receiver: 5-8 data bits, optional parity, 1/2 stop bits.
// Define UART_RX_BREAK_DET_EN to enable break detection and the WAIT_IDLE state.
module uart_rx #(
    parameter int unsigned SAMPLING_RATE = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_rx,
    input  logic [1:0] i_data_len,
    input  logic       i_parity_en,
    input  logic       i_parity_odd,
    input  logic       i_stop2,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_break,
    output logic       o_busy
);
    localparam int unsigned CNT_W = $clog2(SAMPLING_RATE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLING_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(SAMPLING_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
`ifdef UART_RX_BREAK_DET_EN
        S_STOP,
        S_WAIT_IDLE
`else
        S_STOP
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [1:0]             cfg_len_q, cfg_len_d;
    logic                   cfg_par_en_q, cfg_par_en_d;
    logic                   cfg_odd_q, cfg_odd_d;
    logic                   cfg_stop2_q, cfg_stop2_d;
    logic                   par_flag_q, par_flag_d;
    logic                   frm_flag_q, frm_flag_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic                   rx_s;
    logic [7:0]             data_mask;
    logic                   exp_par;
    logic                   last_data;
    logic                   frm_flag_new;
`ifdef UART_RX_BREAK_DET_EN
    logic                   all_zero_q, all_zero_d;
    logic                   break_q, break_d;
    logic                   zero_new;
`endif

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign data_mask = 8'hFF >> (2'd3 - cfg_len_q);
    assign exp_par   = (^(shift_q & data_mask)) ^ cfg_odd_q;
    assign last_data = (bit_cnt_q == ({1'b0, cfg_len_q} + 3'd4));

    // Next-state, counters and registered outputs; everything but o_valid moves on ticks only
    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], i_rx};
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        cfg_len_d    = cfg_len_q;
        cfg_par_en_d = cfg_par_en_q;
        cfg_odd_d    = cfg_odd_q;
        cfg_stop2_d  = cfg_stop2_q;
        par_flag_d   = par_flag_q;
        frm_flag_d   = frm_flag_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        frm_flag_new = frm_flag_q | ~rx_s;
`ifdef UART_RX_BREAK_DET_EN
        all_zero_d   = all_zero_q;
        break_d      = break_q;
        zero_new     = all_zero_q & ~rx_s;
`endif
        if (i_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d      = S_START;
                        tick_cnt_d   = '0;
                        shift_d      = '0;
                        par_flag_d   = 1'b0;
                        frm_flag_d   = 1'b0;
                        cfg_len_d    = i_data_len;
                        cfg_par_en_d = i_parity_en;
                        cfg_odd_d    = i_parity_odd;
                        cfg_stop2_d  = i_stop2;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero_d   = 1'b1;
`endif
                    end
                end
                S_START: begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    if (tick_cnt_q == HALF_LAST) begin
                        if (!rx_s) begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_cnt_q] = rx_s;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero_d         = zero_new;
`endif
                        if (last_data) begin
                            bit_cnt_d = '0;
                            state_d   = cfg_par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                        if (rx_s != exp_par) par_flag_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero_d = zero_new;
`endif
                    end
                end
                S_STOP: begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        frm_flag_d = frm_flag_new;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero_d = zero_new;
`endif
                        if (cfg_stop2_q && (bit_cnt_q == 3'd0)) begin
                            bit_cnt_d = 3'd1;
                        end else begin
                            bit_cnt_d    = '0;
                            data_d       = shift_q & data_mask;
                            parity_err_d = par_flag_q;
                            frame_err_d  = frm_flag_new;
                            valid_d      = 1'b1;
                            state_d      = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                            break_d      = zero_new;
                            if (zero_new) state_d = S_WAIT_IDLE;
`endif
                        end
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                S_WAIT_IDLE: begin
                    if (rx_s) state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= '1;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            cfg_len_q    <= '0;
            cfg_par_en_q <= 1'b0;
            cfg_odd_q    <= 1'b0;
            cfg_stop2_q  <= 1'b0;
            par_flag_q   <= 1'b0;
            frm_flag_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q   <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            cfg_len_q    <= cfg_len_d;
            cfg_par_en_q <= cfg_par_en_d;
            cfg_odd_q    <= cfg_odd_d;
            cfg_stop2_q  <= cfg_stop2_d;
            par_flag_q   <= par_flag_d;
            frm_flag_q   <= frm_flag_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_BREAK_DET_EN
            all_zero_q   <= all_zero_d;
            break_q      <= break_d;
`endif
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_busy       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
    assign o_break      = break_q;
`else
    assign o_break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, corner sequences and random frames
// checked against a line-level decoding model. Honours UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int unsigned SR       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLKS = SR * TICK_DIV;
`ifdef UART_RX_BREAK_DET_EN
    localparam logic BRK = 1'b1;
`else
    localparam logic BRK = 1'b0;
`endif

    logic       i_clk, i_rst_n, i_tick, i_rx;
    logic [1:0] i_data_len;
    logic       i_parity_en, i_parity_odd, i_stop2;
    logic [7:0] o_data;
    logic       o_valid, o_parity_err, o_frame_err, o_break, o_busy;

    uart_rx #(.SAMPLING_RATE(SR), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(i_rx),
        .i_data_len(i_data_len), .i_parity_en(i_parity_en),
        .i_parity_odd(i_parity_odd), .i_stop2(i_stop2),
        .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
        .o_frame_err(o_frame_err), .o_break(o_break), .o_busy(o_busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe, fe, br;
        longint     cyc;
    } cap_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] len;
        logic       pen, odd, st2, flip, s1, s2;
        logic [7:0] exp_data;
        logic       exp_pe, exp_fe, exp_br;
    } vec_t;

    cap_t   mq[$];
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     width_err = 0;
    logic   prev_valid = 1'b0;
    vec_t   vt[9];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // One-clock tick every TICK_DIV clocks
    initial begin
        i_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(posedge i_clk);
            #1 i_tick = 1'b1;
            @(posedge i_clk);
            #1 i_tick = 1'b0;
        end
    end

    // Capture every o_valid pulse and flag pulses wider than one clock
    always @(negedge i_clk) begin
        cap_t c;
        if (o_valid) begin
            c.d = o_data; c.pe = o_parity_err; c.fe = o_frame_err; c.br = o_break; c.cyc = cyc;
            mq.push_back(c);
            if (prev_valid) width_err = width_err + 1;
        end
        prev_valid = o_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] len, input logic pen, input logic odd, input logic st2);
        i_data_len = len; i_parity_en = pen; i_parity_odd = odd; i_stop2 = st2;
    endtask

    // Stimulus side: line bits for a frame, with optional bad parity and chosen stop levels
    task automatic build_frame(input logic [7:0] data, input logic [1:0] len,
                               input logic pen, input logic odd, input logic st2,
                               input logic flip, input logic s1, input logic s2,
                               output logic [15:0] fb, output int nb);
        int   n;
        logic p;
        n = int'(len) + 5;
        fb = '0;
        p = odd;
        for (int i = 0; i < n; i++) begin
            fb[1 + i] = data[i];
            p = p ^ data[i];
        end
        nb = 1 + n;
        if (pen) begin fb[nb] = p ^ flip; nb++; end
        fb[nb] = s1; nb++;
        if (st2) begin fb[nb] = s2; nb++; end
    endtask

    // Reference decoder: what a receiver must report for a given line bit sequence
    task automatic model(input logic [15:0] fb, input int nb, input logic [1:0] len,
                         input logic pen, input logic odd,
                         output logic [7:0] ed, output logic ep, output logic ef, output logic eb);
        int n, ones, pos, want;
        n = int'(len) + 5;
        ed = 8'h00;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            ed[i] = fb[1 + i];
            ones += int'(fb[1 + i]);
        end
        pos = 1 + n;
        ep = 1'b0;
        if (pen) begin
            want = odd ? 1 - (ones % 2) : ones % 2;
            ep = (int'(fb[pos]) != want);
            pos++;
        end
        ef = 1'b0;
        for (int i = pos; i < nb; i++) if (fb[i] == 1'b0) ef = 1'b1;
        eb = BRK;
        for (int i = 1; i < nb; i++) if (fb[i] == 1'b1) eb = 1'b0;
    endtask

    // Drive one frame; called aligned #1 after a posedge. Config is scrambled once latched.
    task automatic drive_frame(input string tag, input logic [15:0] fb, input int nb, output longint edge_cyc);
        edge_cyc = 0;
        for (int b = 0; b < nb; b++) begin
            i_rx = fb[b];
            if (b == 0) edge_cyc = cyc;
            for (int c = 0; c < int'(BIT_CLKS); c++) begin
                @(posedge i_clk); #1;
                if (b == 0 && c == 15) set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                if (b == 1 && c == 31) check({tag, ":busy_mid"}, 32'(o_busy), 32'd1);
            end
        end
        i_rx = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] fb, input int nb,
                             input logic [1:0] len, input logic pen, input logic odd, input logic st2,
                             input logic [7:0] ed, input logic ep, input logic ef, input logic eb);
        longint e, lat, lo;
        cap_t   c;
        set_cfg(len, pen, odd, st2);
        mq.delete();
        drive_frame(tag, fb, nb, e);
        repeat (2 * BIT_CLKS) @(posedge i_clk);
        #1;
        check({tag, ":count"}, 32'(mq.size()), 32'd1);
        if (mq.size() > 0) begin
            c = mq.pop_front();
            check({tag, ":data"}, 32'(c.d), 32'(ed));
            check({tag, ":perr"}, 32'(c.pe), 32'(ep));
            check({tag, ":ferr"}, 32'(c.fe), 32'(ef));
            check({tag, ":brk"}, 32'(c.br), 32'(eb));
            lat = c.cyc - e;
            lo  = 64'(BIT_CLKS) * 64'(nb - 1) + 64'(BIT_CLKS / 2);
            vectors++;
            if (lat < lo || lat > lo + 10) begin
                miscompares++;
                $display("FAIL %s:latency got %0d clocks expected %0d..%0d", tag, lat, lo, lo + 10);
            end
        end
        check({tag, ":busy_idle"}, 32'(o_busy), 32'd0);
        check({tag, ":hold_perr"}, 32'(o_parity_err), 32'(ep));
        check({tag, ":hold_ferr"}, 32'(o_frame_err), 32'(ef));
    endtask

    initial begin
        logic [15:0] fb;
        int          nb;
        logic [7:0]  ed, data;
        logic        ep, ef, eb, pen, odd, st2;
        logic [1:0]  len;
        cap_t        c;

        //        data   len   pen odd st2 flip s1 s2  exp_d  pe fe br
        vt[0] = '{8'hA5, 2'd3, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0, 0};
        vt[1] = '{8'h35, 2'd2, 1, 0, 0, 0, 1, 1, 8'h35, 0, 0, 0};
        vt[2] = '{8'h35, 2'd2, 1, 0, 0, 1, 1, 1, 8'h35, 1, 0, 0};
        vt[3] = '{8'h1F, 2'd0, 1, 1, 1, 0, 1, 0, 8'h1F, 0, 1, 0};
        vt[4] = '{8'hFF, 2'd1, 0, 0, 0, 0, 1, 1, 8'h3F, 0, 0, 0};
        vt[5] = '{8'h00, 2'd3, 1, 1, 0, 0, 1, 1, 8'h00, 0, 0, 0};
        vt[6] = '{8'h80, 2'd3, 1, 0, 1, 0, 0, 1, 8'h80, 0, 1, 0};
        vt[7] = '{8'h15, 2'd0, 1, 0, 0, 1, 1, 1, 8'h15, 1, 0, 0};
        vt[8] = '{8'h00, 2'd3, 0, 0, 0, 0, 0, 1, 8'h00, 0, 1, BRK};

        i_rst_n = 1'b0;
        i_rx = 1'b1;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        check("rst:data", 32'(o_data), 32'd0);
        check("rst:valid", 32'(o_valid), 32'd0);
        check("rst:perr", 32'(o_parity_err), 32'd0);
        check("rst:ferr", 32'(o_frame_err), 32'd0);
        check("rst:brk", 32'(o_break), 32'd0);
        check("rst:busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            build_frame(vt[i].data, vt[i].len, vt[i].pen, vt[i].odd, vt[i].st2,
                        vt[i].flip, vt[i].s1, vt[i].s2, fb, nb);
            run_frame($sformatf("tbl%0d", i), fb, nb, vt[i].len, vt[i].pen, vt[i].odd, vt[i].st2,
                      vt[i].exp_data, vt[i].exp_pe, vt[i].exp_fe, vt[i].exp_br);
        end

        // Start glitch shorter than half a bit must be dropped silently
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        mq.delete();
        i_rx = 1'b0;
        repeat (3 * TICK_DIV) @(posedge i_clk);
        #1;
        check("glitch:busy", 32'(o_busy), 32'd1);
        i_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge i_clk);
        #1;
        check("glitch:count", 32'(mq.size()), 32'd0);
        check("glitch:idle", 32'(o_busy), 32'd0);
        build_frame(8'h3C, 2'd3, 0, 0, 0, 0, 1, 1, fb, nb);
        run_frame("after_glitch", fb, nb, 2'd3, 0, 0, 0, 8'h3C, 0, 0, 0);

        // Reset in the middle of data bit 3 of 0xFF
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        mq.delete();
        build_frame(8'hFF, 2'd3, 0, 0, 0, 0, 1, 1, fb, nb);
        for (int b = 0; b < 5; b++) begin
            i_rx = fb[b];
            repeat ((b == 4) ? BIT_CLKS / 2 : BIT_CLKS) @(posedge i_clk);
            #1;
        end
        check("rstmid:busy_before", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("rstmid:data", 32'(o_data), 32'd0);
        check("rstmid:valid", 32'(o_valid), 32'd0);
        check("rstmid:busy", 32'(o_busy), 32'd0);
        check("rstmid:ferr", 32'(o_frame_err), 32'd0);
        i_rx = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge i_clk);
        #1;
        check("rstmid:count", 32'(mq.size()), 32'd0);
        build_frame(8'h81, 2'd3, 0, 0, 0, 0, 1, 1, fb, nb);
        run_frame("after_rst", fb, nb, 2'd3, 0, 0, 0, 8'h81, 0, 0, 0);

        // Line held low for 20 bit periods
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        mq.delete();
        i_rx = 1'b0;
        repeat (19 * BIT_CLKS) @(posedge i_clk);
        #1;
        if (BRK) check("stuck:busy_low_line", 32'(o_busy), 32'd1);
        repeat (BIT_CLKS) @(posedge i_clk);
        #1;
        i_rx = 1'b1;
        if (BRK) begin
            repeat (2 * BIT_CLKS) @(posedge i_clk);
            #1;
            check("stuck:busy_released", 32'(o_busy), 32'd0);
            check("stuck:count", 32'(mq.size()), 32'd1);
        end else begin
            repeat (12 * BIT_CLKS) @(posedge i_clk);
            #1;
            check("stuck:count_ge2", 32'(mq.size() >= 2), 32'd1);
        end
        for (int k = 0; k < 2 && mq.size() > 0; k++) begin
            c = mq.pop_front();
            check($sformatf("stuck%0d:data", k), 32'(c.d), 32'd0);
            check($sformatf("stuck%0d:ferr", k), 32'(c.fe), 32'd1);
            check($sformatf("stuck%0d:brk", k), 32'(c.br), 32'(BRK));
            if (BRK) break;
        end
        mq.delete();
        build_frame(8'h55, 2'd3, 0, 0, 0, 0, 1, 1, fb, nb);
        run_frame("after_stuck", fb, nb, 2'd3, 0, 0, 0, 8'h55, 0, 0, 0);

        // Random frames against the reference decoder
        for (int r = 0; r < 24; r++) begin
            len  = 2'($urandom);
            pen  = 1'($urandom);
            odd  = 1'($urandom);
            st2  = 1'($urandom);
            data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            fb = '0;
            for (int i = 0; i < int'(len) + 5; i++) fb[1 + i] = data[i];
            nb = int'(len) + 6;
            if (pen) begin fb[nb] = 1'($urandom); nb++; end
            fb[nb] = ($urandom_range(0, 4) != 0); nb++;
            if (st2) begin fb[nb] = ($urandom_range(0, 4) != 0); nb++; end
            model(fb, nb, len, pen, odd, ed, ep, ef, eb);
            run_frame($sformatf("rnd%0d", r), fb, nb, len, pen, odd, st2, ed, ep, ef, eb);
        end

        check("valid_width", 32'(width_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
